// File: rtl/matrix_max7219_sender_if.sv
// Row-register bus between the game blocks and the MAX7219 sender, plus the 3-wire
// serial link and status outputs. The row source drives master; the sender is slave.
interface matrix_max7219_sender_if #(
  parameter int DATAWIDTH_BUS = 8
);
  logic [DATAWIDTH_BUS-1:0] MS_ROW0_IN;
  logic [DATAWIDTH_BUS-1:0] MS_ROW1_IN;
  logic [DATAWIDTH_BUS-1:0] MS_ROW2_IN;
  logic [DATAWIDTH_BUS-1:0] MS_ROW3_IN;
  logic [DATAWIDTH_BUS-1:0] MS_ROW4_IN;
  logic [DATAWIDTH_BUS-1:0] MS_ROW5_IN;
  logic [DATAWIDTH_BUS-1:0] MS_ROW6_IN;
  logic [DATAWIDTH_BUS-1:0] MS_ROW7_IN;
  logic                     MS_DIN_OUT;
  logic                     MS_SCLK_OUT;
  logic                     MS_LOAD_OUT;
  logic                     MS_INIT_DONE_OUT;
  logic                     MS_FRAME_OUT;

  modport master (
    output MS_ROW0_IN, MS_ROW1_IN, MS_ROW2_IN, MS_ROW3_IN,
           MS_ROW4_IN, MS_ROW5_IN, MS_ROW6_IN, MS_ROW7_IN,
    input  MS_DIN_OUT, MS_SCLK_OUT, MS_LOAD_OUT, MS_INIT_DONE_OUT, MS_FRAME_OUT
  );

  modport slave (
    input  MS_ROW0_IN, MS_ROW1_IN, MS_ROW2_IN, MS_ROW3_IN,
           MS_ROW4_IN, MS_ROW5_IN, MS_ROW6_IN, MS_ROW7_IN,
    output MS_DIN_OUT, MS_SCLK_OUT, MS_LOAD_OUT, MS_INIT_DONE_OUT, MS_FRAME_OUT
  );
endinterface

// File: rtl/matrix_max7219_sender.sv
// Serialises eight row buses to a MAX7219: five init words once after reset, then
// refreshes digits 1..8 forever. One FSM state per divided tick; all outputs registered.
module matrix_max7219_sender #(
  parameter int          DATAWIDTH_BUS = 8,
  parameter int          CLKDIV        = 25,
  parameter logic [3:0]  INTENSITY     = 4'h8,
  parameter bit          INVERT        = 1'b0
) (
  input  logic                      CC_CLOCK_50,
  input  logic                      CC_RESET,
  matrix_max7219_sender_if.slave    ms_bus
);
  localparam int DIV_W = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;

  typedef enum logic [2:0] {LOAD_WORD, SHIFT_HI, SHIFT_LO, LATCH, LOAD_HI} state_t;

  state_t                   state_reg, state_next;
  logic [DIV_W-1:0]         div_reg;
  logic [3:0]               index_reg, index_next;
  logic [15:0]              shreg_reg, shreg_next;
  logic [3:0]               bit_cnt_reg, bit_cnt_next;
  logic                     din_reg, din_next;
  logic                     sclk_reg, sclk_next;
  logic                     load_reg, load_next;
  logic                     init_done_reg, init_done_next;
  logic                     frame_reg, frame_next;
  logic                     tick;
  logic [DATAWIDTH_BUS-1:0] row_bus [8];
  logic [3:0]               row_sel;
  logic [DATAWIDTH_BUS-1:0] row_data;
  logic [15:0]              word;

  assign row_bus[0] = ms_bus.MS_ROW0_IN;
  assign row_bus[1] = ms_bus.MS_ROW1_IN;
  assign row_bus[2] = ms_bus.MS_ROW2_IN;
  assign row_bus[3] = ms_bus.MS_ROW3_IN;
  assign row_bus[4] = ms_bus.MS_ROW4_IN;
  assign row_bus[5] = ms_bus.MS_ROW5_IN;
  assign row_bus[6] = ms_bus.MS_ROW6_IN;
  assign row_bus[7] = ms_bus.MS_ROW7_IN;

  assign tick = (div_reg == DIV_W'(CLKDIV - 1));

  // Word for the current index; only sampled in the LOAD_WORD tick, so rows are captured there.
  always_comb begin
    row_sel  = index_reg - 4'd5;
    row_data = INVERT ? ~row_bus[row_sel[2:0]] : row_bus[row_sel[2:0]];
    word     = 16'h0000;
    case (index_reg)
      4'd0:    word = 16'h0C01;
      4'd1:    word = 16'h0F00;
      4'd2:    word = 16'h0900;
      4'd3:    word = {8'h0A, 4'h0, INTENSITY};
      4'd4:    word = 16'h0B07;
      default: word = {4'h0, index_reg - 4'd4, row_data};
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    index_next     = index_reg;
    shreg_next     = shreg_reg;
    bit_cnt_next   = bit_cnt_reg;
    din_next       = din_reg;
    sclk_next      = sclk_reg;
    load_next      = load_reg;
    init_done_next = init_done_reg;
    frame_next     = 1'b0;
    case (state_reg)
      LOAD_WORD: begin
        load_next    = 1'b0;
        sclk_next    = 1'b0;
        din_next     = word[15];
        shreg_next   = {word[14:0], 1'b0};
        bit_cnt_next = 4'd15;
        state_next   = SHIFT_HI;
      end
      SHIFT_HI: begin
        sclk_next  = 1'b1;
        state_next = (bit_cnt_reg == 4'd0) ? LATCH : SHIFT_LO;
      end
      SHIFT_LO: begin
        sclk_next    = 1'b0;
        din_next     = shreg_reg[15];
        shreg_next   = {shreg_reg[14:0], 1'b0};
        bit_cnt_next = bit_cnt_reg - 4'd1;
        state_next   = SHIFT_HI;
      end
      LATCH: begin
        sclk_next  = 1'b0;
        load_next  = 1'b0;
        state_next = LOAD_HI;
      end
      LOAD_HI: begin
        load_next  = 1'b1;
        state_next = LOAD_WORD;
        if (index_reg == 4'd4) init_done_next = 1'b1;
        if (index_reg == 4'd12) begin
          frame_next = 1'b1;
          index_next = 4'd5;
        end else begin
          index_next = index_reg + 4'd1;
        end
      end
      default: state_next = LOAD_WORD;
    endcase
  end

  always_ff @(posedge CC_CLOCK_50 or posedge CC_RESET) begin
    if (CC_RESET) begin
      state_reg     <= LOAD_WORD;
      div_reg       <= '0;
      index_reg     <= 4'd0;
      shreg_reg     <= 16'h0000;
      bit_cnt_reg   <= 4'd0;
      din_reg       <= 1'b0;
      sclk_reg      <= 1'b0;
      load_reg      <= 1'b1;
      init_done_reg <= 1'b0;
      frame_reg     <= 1'b0;
    end else begin
      div_reg   <= tick ? '0 : div_reg + DIV_W'(1);
      frame_reg <= tick & frame_next;
      if (tick) begin
        state_reg     <= state_next;
        index_reg     <= index_next;
        shreg_reg     <= shreg_next;
        bit_cnt_reg   <= bit_cnt_next;
        din_reg       <= din_next;
        sclk_reg      <= sclk_next;
        load_reg      <= load_next;
        init_done_reg <= init_done_next;
      end
    end
  end

  assign ms_bus.MS_DIN_OUT       = din_reg;
  assign ms_bus.MS_SCLK_OUT      = sclk_reg;
  assign ms_bus.MS_LOAD_OUT      = load_reg;
  assign ms_bus.MS_INIT_DONE_OUT = init_done_reg;
  assign ms_bus.MS_FRAME_OUT     = frame_reg;
endmodule

// File: tb/tb_matrix_max7219_sender.sv
// Directed bench: decodes the serial words from two senders (normal and inverted rows)
// and compares them against a scoreboard of expected words.
module tb_matrix_max7219_sender;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rows [8];
  bit         sel = 1'b0;
  int         total = 0;
  int         bad = 0;
  logic [15:0] exp_q [$];
  time        prev_rise_t = 0;
  time        last_frame_t = 0;
  bit         first_word = 1'b1;

  always #5 clk = ~clk;

  matrix_max7219_sender_if #(.DATAWIDTH_BUS(8)) bus1 ();
  matrix_max7219_sender_if #(.DATAWIDTH_BUS(8)) bus2 ();

  matrix_max7219_sender #(.DATAWIDTH_BUS(8), .CLKDIV(2), .INTENSITY(4'h8), .INVERT(1'b0)) dut1 (
    .CC_CLOCK_50(clk), .CC_RESET(rst), .ms_bus(bus1.slave));
  matrix_max7219_sender #(.DATAWIDTH_BUS(8), .CLKDIV(2), .INTENSITY(4'h8), .INVERT(1'b1)) dut2 (
    .CC_CLOCK_50(clk), .CC_RESET(rst), .ms_bus(bus2.slave));

  assign bus1.MS_ROW0_IN = rows[0];  assign bus2.MS_ROW0_IN = rows[0];
  assign bus1.MS_ROW1_IN = rows[1];  assign bus2.MS_ROW1_IN = rows[1];
  assign bus1.MS_ROW2_IN = rows[2];  assign bus2.MS_ROW2_IN = rows[2];
  assign bus1.MS_ROW3_IN = rows[3];  assign bus2.MS_ROW3_IN = rows[3];
  assign bus1.MS_ROW4_IN = rows[4];  assign bus2.MS_ROW4_IN = rows[4];
  assign bus1.MS_ROW5_IN = rows[5];  assign bus2.MS_ROW5_IN = rows[5];
  assign bus1.MS_ROW6_IN = rows[6];  assign bus2.MS_ROW6_IN = rows[6];
  assign bus1.MS_ROW7_IN = rows[7];  assign bus2.MS_ROW7_IN = rows[7];

  logic cur_din, cur_sclk, cur_load, cur_init, cur_frame;
  assign cur_din   = sel ? bus2.MS_DIN_OUT       : bus1.MS_DIN_OUT;
  assign cur_sclk  = sel ? bus2.MS_SCLK_OUT      : bus1.MS_SCLK_OUT;
  assign cur_load  = sel ? bus2.MS_LOAD_OUT      : bus1.MS_LOAD_OUT;
  assign cur_init  = sel ? bus2.MS_INIT_DONE_OUT : bus1.MS_INIT_DONE_OUT;
  assign cur_frame = sel ? bus2.MS_FRAME_OUT     : bus1.MS_FRAME_OUT;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] exp_word(input int idx, input bit inv);
    logic [7:0] d;
    case (idx)
      0: return 16'h0C01;
      1: return 16'h0F00;
      2: return 16'h0900;
      3: return 16'h0A08;
      4: return 16'h0B07;
      default: begin
        d = rows[idx - 5];
        if (inv) d = ~d;
        return {4'h0, 4'(idx - 4), d};
      end
    endcase
  endfunction

  // Decode one word: wait for LOAD low, shift DIN on SCLK rises, end on LOAD rise.
  task automatic collect_word(input bit mid_change, input logic [7:0] new_row7,
                              output logic [15:0] w, output int rises, output int frames,
                              output bit ok);
    int budget;
    bit started, changed;
    logic prev_sclk;
    w = 16'h0000; rises = 0; frames = 0; ok = 1'b0;
    budget = 0; started = 1'b0; changed = 1'b0;
    prev_sclk = cur_sclk;
    while (budget < 400) begin
      @(negedge clk);
      budget++;
      if (cur_frame === 1'b1) begin
        frames++;
        last_frame_t = $time;
      end
      if (cur_load === 1'b0) started = 1'b1;
      if (started && cur_sclk === 1'b1 && prev_sclk === 1'b0) begin
        w = {w[14:0], cur_din};
        rises++;
      end
      prev_sclk = cur_sclk;
      if (started && mid_change && !changed) begin
        rows[7] = new_row7;
        changed = 1'b1;
      end
      if (started && cur_load === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_word(input int idx, input bit inv, input bit mid_change,
                          input logic [7:0] new_row7);
    logic [15:0] w, expv;
    int rises, frames, len;
    bit ok;
    exp_q.push_back(exp_word(idx, inv));
    collect_word(mid_change, new_row7, w, rises, frames, ok);
    expv = exp_q.pop_front();
    check($sformatf("done_idx%0d", idx), 32'(ok), 32'd1);
    if (!ok) return;
    check($sformatf("word_idx%0d", idx), 32'(w), 32'(expv));
    check($sformatf("sclk_rises_idx%0d", idx), 32'(rises), 32'd16);
    check($sformatf("init_done_idx%0d", idx), 32'(cur_init), 32'(idx >= 4));
    check($sformatf("frames_idx%0d", idx), 32'(frames), 32'(idx == 12));
    len = int'(($time - prev_rise_t) / 10);
    if (!first_word) check($sformatf("len_idx%0d", idx), 32'(len), 32'd68);
    prev_rise_t = $time;
    first_word = 1'b0;
    $display("word idx=%0d got=0x%04h exp=0x%04h rises=%0d frames=%0d init_done=%0b",
             idx, w, expv, rises, frames, cur_init);
  endtask

  initial begin
    time t1, t2, t3;
    int budget;
    rows[0] = 8'h01; rows[1] = 8'h11; rows[2] = 8'h22; rows[3] = 8'h33;
    rows[4] = 8'h44; rows[5] = 8'h55; rows[6] = 8'h66; rows[7] = 8'hB5;
    repeat (3) @(negedge clk);
    check("rst_din", 32'(bus1.MS_DIN_OUT), 32'd0);
    check("rst_sclk", 32'(bus1.MS_SCLK_OUT), 32'd0);
    check("rst_load", 32'(bus1.MS_LOAD_OUT), 32'd1);
    check("rst_init_done", 32'(bus1.MS_INIT_DONE_OUT), 32'd0);
    check("rst_frame", 32'(bus1.MS_FRAME_OUT), 32'd0);
    rst = 1'b0;

    // Init sequence and first frame
    for (int i = 0; i <= 12; i++) run_word(i, 1'b0, 1'b0, 8'h00);
    t1 = last_frame_t;

    // Row 7 changes while its word is in flight
    for (int i = 5; i <= 12; i++) run_word(i, 1'b0, i == 12, 8'hFF);
    t2 = last_frame_t;
    check("frame_interval1", 32'((t2 - t1) / 10), 32'd544);
    for (int i = 5; i <= 12; i++) run_word(i, 1'b0, 1'b0, 8'h00);
    t3 = last_frame_t;
    check("frame_interval2", 32'((t3 - t2) / 10), 32'd544);

    // Asynchronous reset in the middle of a refresh word
    budget = 0;
    while (bus1.MS_LOAD_OUT !== 1'b0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    repeat (9) @(negedge clk);
    check("pre_reset_load_low", 32'(bus1.MS_LOAD_OUT), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("midrst_din", 32'(bus1.MS_DIN_OUT), 32'd0);
    check("midrst_sclk", 32'(bus1.MS_SCLK_OUT), 32'd0);
    check("midrst_load", 32'(bus1.MS_LOAD_OUT), 32'd1);
    check("midrst_init_done", 32'(bus1.MS_INIT_DONE_OUT), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    first_word = 1'b1;
    run_word(0, 1'b0, 1'b0, 8'h00);
    run_word(1, 1'b0, 1'b0, 8'h00);

    // Inverted-row sender after a fresh reset
    @(negedge clk);
    rst = 1'b1;
    rows[7] = 8'hB5;
    repeat (2) @(negedge clk);
    sel = 1'b1;
    rst = 1'b0;
    first_word = 1'b1;
    for (int i = 0; i <= 12; i++) run_word(i, 1'b1, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
